mod_exp_engine: RTL

//  Parametrised modular-exponentiation engine: result = msg^exp mod n.

---
 rtl/rsa_pkg.sv | 15 +
 rtl/mod_exp_engine_if.sv | 29 ++
 rtl/mod_mul_stage.sv | 39 +++
 rtl/mod_exp_engine.sv | 139 +++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared types and defaults for the modular-exponentiation engine.
package rsa_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int EXP_W_DEF  = 16;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_MUL  = 3'd2,
        S_RED  = 3'd3,
        S_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/mod_exp_engine_if.sv
// Request/response bundle of the modular-exponentiation engine.
interface mod_exp_engine_if
    import rsa_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int EXP_W  = EXP_W_DEF
) ();

    logic              start;
    logic [DATA_W-1:0] msg_in;
    logic [EXP_W-1:0]  exp_in;
    logic [DATA_W-1:0] mod_in;
    logic              ready;
    logic              busy;
    logic              done;
    logic              err;
    logic [DATA_W-1:0] result;

    modport master (
        output start, msg_in, exp_in, mod_in,
        input  ready, busy, done, err, result
    );

    modport slave (
        input  start, msg_in, exp_in, mod_in,
        output ready, busy, done, err, result
    );

endinterface

// File: rtl/mod_mul_stage.sv
// One multiply-then-reduce lane: registers a*b on mul_en and (a*b) mod n on red_en.
// The residue register can also be preset with ld_val on ld_en.
module mod_mul_stage #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_en,
    input  logic              mul_en,
    input  logic              red_en,
    input  logic [DATA_W-1:0] ld_val,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] n,
    output logic [DATA_W-1:0] r
);

    logic [2*DATA_W-1:0] p;
    logic [DATA_W-1:0]   rem;

    // The remainder is below n, so it always fits back into DATA_W bits.
    assign rem = (n == '0) ? '0 : DATA_W'(p % {{DATA_W{1'b0}}, n});

    // NOTE: non-blocking updates so both lanes read pre-edge acc/base values.
    always_ff @(posedge clk) begin
        if (reset) begin
            p <= '0;
            r <= '0;
        end else begin
            if (mul_en)
                p <= {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
            if (red_en)
                r <= rem;
            else if (ld_en)
                r <= ld_val;
        end
    end

endmodule

// File: rtl/mod_exp_engine.sv
// Constant-time LSB-first square-and-multiply engine computing msg^exp mod n.
// Always runs EXP_W MUL/RED iterations so latency is independent of operands.
module mod_exp_engine
    import rsa_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int EXP_W  = EXP_W_DEF
) (
    input logic            clk,
    input logic            reset,
    mod_exp_engine_if.slave bus
);

    localparam int CNT_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(EXP_W - 1);

    state_t            state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] msg_q;
    logic [EXP_W-1:0]  exp_q;
    logic [DATA_W-1:0] n_q;
    logic [DATA_W-1:0] result_q;
    logic              ready_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] base;
    logic [DATA_W-1:0] acc_ld;
    logic [DATA_W-1:0] base_ld;
    logic [DATA_W-1:0] mul_b;
    logic              ld_en;
    logic              mul_en;
    logic              red_en;

    assign ld_en  = (state == S_LOAD);
    assign mul_en = (state == S_MUL);
    assign red_en = (state == S_RED);

    // acc starts at 1 mod n; n==0 also yields 0 so the error result reads 0.
    assign acc_ld  = (n_q <= DATA_W'(1)) ? '0 : DATA_W'(1);
    assign base_ld = (n_q == '0) ? '0 : msg_q % n_q;
    assign mul_b   = exp_q[bit_cnt] ? base : DATA_W'(1);

    mod_mul_stage #(.DATA_W(DATA_W)) u_mul (
        .clk    (clk),
        .reset  (reset),
        .ld_en  (ld_en),
        .mul_en (mul_en),
        .red_en (red_en),
        .ld_val (acc_ld),
        .a      (acc),
        .b      (mul_b),
        .n      (n_q),
        .r      (acc)
    );

    mod_mul_stage #(.DATA_W(DATA_W)) u_sqr (
        .clk    (clk),
        .reset  (reset),
        .ld_en  (ld_en),
        .mul_en (mul_en),
        .red_en (red_en),
        .ld_val (base_ld),
        .a      (base),
        .b      (base),
        .n      (n_q),
        .r      (base)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            bit_cnt  <= '0;
            msg_q    <= '0;
            exp_q    <= '0;
            n_q      <= '0;
            result_q <= '0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            // NOTE: default-low here makes done a single-cycle pulse without extra logic.
            done_q <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (state == S_DONE)
                        result_q <= acc;
                    if (bus.start) begin
                        msg_q   <= bus.msg_in;
                        exp_q   <= bus.exp_in;
                        n_q     <= bus.mod_in;
                        bit_cnt <= '0;
                        err_q   <= 1'b0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state   <= S_LOAD;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_LOAD: begin
                    if (n_q == '0) begin
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state   <= S_DONE;
                    end else begin
                        state <= S_MUL;
                    end
                end
                S_MUL: state <= S_RED;
                S_RED: begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    if (bit_cnt == LAST_BIT) begin
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state   <= S_DONE;
                    end else begin
                        state <= S_MUL;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // While in DONE the fresh accumulator is shown; it is latched on leaving DONE.
    assign bus.result = (state == S_DONE) ? acc : result_q;
    assign bus.ready  = ready_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;

endmodule
